slow_memory: RTL and testbench

//  - Behavioural-timing off-chip memory model: one 128-bit line per access, fixed multi-cycle latency, one-cycle ready pulse.
//  - Two instances sit beside CHIP: one for data (D-cache refills/writebacks), one for instructions (I-cache refills).
//  - Contents are preloaded by the bench via $readmemb/$readmemh into array `mem`; the array is not cleared by reset.

---
 rtl/slow_memory.sv | 134 +++++++++++++
 tb/tb_slow_memory.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/slow_memory.sv
// slow_memory: off-chip line memory model, one 128-bit line per access, fixed latency, one-cycle ready pulse.
// Define SLOW_MEM_RANDLAT_EN to add 0..3 cycles of LFSR-driven extra latency per accepted access.
module slow_memory #(
  parameter int LATENCY = 8,
  parameter int ADDR_W  = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready
);

  localparam int CNT_W = $clog2(LATENCY + 4) + 1;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [127:0] mem [0:(2**ADDR_W)-1];

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s, target_s;
  logic               write_r;
  logic [ADDR_W-1:0]  idx_r;
  logic [127:0]       wdata_r;
  logic               accept_s, complete_s, req_live_s;
  logic               unused_addr_s;

  // Address bits above the index alias onto the same lines.
  assign unused_addr_s = ^mem_addr[27:ADDR_W];
  assign req_live_s    = write_r ? mem_write : mem_read;

`ifdef SLOW_MEM_RANDLAT_EN
  logic [7:0] lfsr_r;
  logic [1:0] extra_r;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Per-access extra latency drawn from the LFSR, which steps after each use.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_r  <= 8'hA5;
      extra_r <= 2'd0;
    end else if (accept_s) begin
      extra_r <= lfsr_r[1:0];
      lfsr_r  <= lfsr_next(lfsr_r);
    end
  end

  assign target_s = LAT_C + CNT_W'(extra_r);
`else
  assign target_s = LAT_C;
`endif

  // Next-state and access-event decode.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    accept_s   = 1'b0;
    complete_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept_s = 1'b1;
          cnt_s    = CNT_W'(1);
          state_s  = BUSY;
        end else begin
          state_s  = IDLE;
        end
      end
      BUSY: begin
        if (!req_live_s) begin
          cnt_s   = CNT_W'(0);
          state_s = IDLE;
        end else if (cnt_r == target_s) begin
          complete_s = 1'b1;
          cnt_s      = CNT_W'(0);
          state_s    = DONE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        cnt_s   = CNT_W'(0);
        state_s = IDLE;
      end
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_W'(0);
      write_r   <= 1'b0;
      idx_r     <= {ADDR_W{1'b0}};
      wdata_r   <= 128'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 128'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      mem_ready <= complete_s;
      if (accept_s) begin
        write_r <= mem_write;
        idx_r   <= mem_addr[ADDR_W-1:0];
        wdata_r <= mem_wdata;
      end
      if (complete_s && !write_r) begin
        mem_rdata <= mem[idx_r];
      end
    end
  end

  // Storage array; deliberately untouched by reset so preloaded contents survive.
  always_ff @(posedge clk) begin
    if (rst_n && complete_s && write_r) begin
      mem[idx_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_slow_memory.sv
// tb_slow_memory: directed table-driven checks of slow_memory plus hand-written abort/reset/back-to-back sequences.
module tb_slow_memory;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] P5   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] PTOP = 128'hFEDCBA9876543210FEDCBA9876543210;
  localparam logic [127:0] P9   = 128'h99990000999900009999000099990000;
  localparam logic [127:0] W7   = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
  localparam logic [127:0] W3   = 128'h33333333333333333333333333333333;
  localparam logic [127:0] W9   = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;

  slow_memory dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one access, hold it until ready, then release and check the pulse ends.
  task automatic do_access(input string name, input logic rd, input logic wr,
                           input logic [27:0] addr, input logic [127:0] wdata,
                           input logic [127:0] exp_rdata);
    int lat;
    lat       = -1;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    for (int e = 0; e <= 20; e++) begin
      step();
      if (mem_ready && lat < 0) lat = e;
      if (lat >= 0) break;
    end
    chk({name, "_latency"}, 128'(lat), 128'd8);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    chk({name, "_rdata"}, mem_rdata, exp_rdata);
    step();
    chk({name, "_ready_one_cycle"}, 128'(mem_ready), 128'd0);
    chk({name, "_rdata_held"}, mem_rdata, exp_rdata);
  endtask

  initial begin
    vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 28'h0000005, wdata: 128'd0, exp_rdata: P5};
    vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 28'h0000007, wdata: W7,     exp_rdata: P5};
    vecs[2] = '{rd: 1'b1, wr: 1'b0, addr: 28'h0000007, wdata: 128'd0, exp_rdata: W7};
    vecs[3] = '{rd: 1'b1, wr: 1'b1, addr: 28'h0000003, wdata: W3,     exp_rdata: W7};
    vecs[4] = '{rd: 1'b1, wr: 1'b0, addr: 28'h0000003, wdata: 128'd0, exp_rdata: W3};
    vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 28'hFFFF805, wdata: 128'd0, exp_rdata: P5};
    vecs[6] = '{rd: 1'b1, wr: 1'b0, addr: 28'h00007FF, wdata: 128'd0, exp_rdata: PTOP};

    dut.mem[5]    = P5;
    dut.mem[3]    = 128'd0;
    dut.mem[7]    = 128'd0;
    dut.mem[9]    = P9;
    dut.mem[2047] = PTOP;

    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 28'd0;
    mem_wdata = 128'd0;
    repeat (3) step();
    chk("reset_ready", 128'(mem_ready), 128'd0);
    chk("reset_rdata", mem_rdata, 128'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      do_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_rdata);
    end

    // Abort: read line 5 dropped after the fourth BUSY edge; rdata still holds PTOP.
    mem_read = 1'b1;
    mem_addr = 28'h0000005;
    step();
    for (int e = 1; e <= 4; e++) step();
    mem_read = 1'b0;
    for (int e = 5; e <= 16; e++) begin
      step();
      chk($sformatf("abort_no_ready_e%0d", e), 128'(mem_ready), 128'd0);
    end
    chk("abort_rdata_unchanged", mem_rdata, PTOP);
    do_access("after_abort", 1'b1, 1'b0, 28'h0000007, 128'd0, W7);

    // Held through ready, dropped after DONE: exactly one pulse.
    mem_read = 1'b1;
    mem_addr = 28'h0000005;
    for (int e = 0; e <= 14; e++) begin
      step();
      chk($sformatf("hold_ready_e%0d", e), 128'(mem_ready), (e == 8) ? 128'd1 : 128'd0);
      if (e == 9) mem_read = 1'b0;
    end
    chk("hold_rdata", mem_rdata, P5);

    // Continuous request: completions at k+8 and k+18.
    mem_read = 1'b1;
    mem_addr = 28'h0000007;
    for (int e = 0; e <= 22; e++) begin
      step();
      chk($sformatf("b2b_ready_e%0d", e), 128'(mem_ready),
          (e == 8 || e == 18) ? 128'd1 : 128'd0);
      if (e == 18) mem_read = 1'b0;
    end
    chk("b2b_rdata", mem_rdata, W7);

    // Reset during a write to line 9 after the fifth BUSY edge.
    mem_write = 1'b1;
    mem_addr  = 28'h0000009;
    mem_wdata = W9;
    step();
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("midwrite_ready_e%0d", e), 128'(mem_ready), 128'd0);
    end
    rst_n     = 1'b0;
    mem_write = 1'b0;
    step();
    chk("midreset_ready", 128'(mem_ready), 128'd0);
    chk("midreset_rdata", mem_rdata, 128'd0);
    rst_n = 1'b1;
    step();
    do_access("line9_kept", 1'b1, 1'b0, 28'h0000009, 128'd0, P9);
    do_access("line5_kept", 1'b1, 1'b0, 28'h0000005, 128'd0, P5);
    do_access("line3_kept", 1'b1, 1'b0, 28'h0000003, 128'd0, W3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
